// File: rtl/mac_unit_pipe.sv
// mac_unit_pipe: systolic-array processing element.
// Signed W x W multiply feeding an ACC_W saturating adder through a 3-stage
// pipeline that only advances when i_step_i is high. Weight-stationary mode
// forwards partial sums downward; output-stationary mode accumulates locally
// and drains the accumulator on a clear step.
//
// Handshake: every *_v_o valid is level-held with the pipeline; a valid is
// consumed exactly once per clock in which step_i is high, and a stalled
// (step_i low) valid must not be re-counted by the consumer.
module mac_unit_pipe #(
    parameter int W     = 8,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    input  logic             mode_i,
    input  logic             clear_i,
    input  logic             data_v_i,
    input  logic [W-1:0]     data_i,
    input  logic [ACC_W-1:0] data_top_i,
    input  logic             wr_weight_v_i,
    input  logic [W-1:0]     weight_i,
    input  logic             weight_swap_i,
    input  logic [2:0]       dbg_addr_i,
    output logic [ACC_W-1:0] dbg_data_o,
    output logic             data_v_o,
    output logic [W-1:0]     data_o,
    output logic             res_v_o,
    output logic [ACC_W-1:0] res_o,
    output logic             sat_o
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Weights: shadow is the load target, active feeds the multiplier.
    logic signed [W-1:0]     r_w_active;
    logic signed [W-1:0]     r_w_shadow;

    // Pipeline registers.
    logic signed [W-1:0]     r_data_q;
    logic                    r_dv_q;
    logic [ACC_W-1:0]        r_top1_q;
    logic signed [2*W-1:0]   r_prod_q;
    logic                    r_pv_q;
    logic [ACC_W-1:0]        r_top2_q;
    logic [ACC_W-1:0]        r_res_q;
    logic                    r_res_v_q;
    logic [ACC_W-1:0]        r_acc_q;
    logic                    r_sat_q;

    // Combinational datapath.
    logic signed [2*W-1:0]   w_mult;
    logic signed [ACC_W:0]   w_prod_ext;
    logic signed [ACC_W:0]   w_ws_sum;
    logic signed [ACC_W:0]   w_os_sum;
    logic                    w_ws_clamp;
    logic                    w_os_clamp;
    logic [ACC_W-1:0]        w_ws_sat;
    logic [ACC_W-1:0]        w_os_sat;

    // Multiply and form both S3 sums one bit wider so overflow is visible.
    always_comb begin
        w_mult     = r_w_active * r_data_q;
        w_prod_ext = (ACC_W+1)'(r_prod_q);
        w_ws_sum   = (ACC_W+1)'($signed(r_top2_q)) + w_prod_ext;
        w_os_sum   = (ACC_W+1)'($signed(r_acc_q)) + w_prod_ext;
    end

    // Signed clamp: overflow when the two top bits of the wide sum disagree.
    always_comb begin
        w_ws_clamp = w_ws_sum[ACC_W] ^ w_ws_sum[ACC_W-1];
        w_os_clamp = w_os_sum[ACC_W] ^ w_os_sum[ACC_W-1];
        w_ws_sat   = w_ws_sum[ACC_W-1:0];
        w_os_sat   = w_os_sum[ACC_W-1:0];
        if (w_ws_clamp) begin
            w_ws_sat = w_ws_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
        if (w_os_clamp) begin
            w_os_sat = w_os_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Weight double buffer: shadow loads on any clock, swap waits for a step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_shadow <= '0;
            r_w_active <= '0;
        end else begin
            if (wr_weight_v_i) begin
                r_w_shadow <= weight_i;
            end
            if (step_i && weight_swap_i) begin
                r_w_active <= r_w_shadow;
            end
        end
    end

    // Stages S1 and S2: operand capture, then multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= '0;
            r_dv_q   <= 1'b0;
            r_top1_q <= '0;
            r_prod_q <= '0;
            r_pv_q   <= 1'b0;
            r_top2_q <= '0;
        end else if (step_i) begin
            r_data_q <= data_i;
            r_dv_q   <= data_v_i;
            r_top1_q <= data_top_i;
            r_prod_q <= w_mult;
            r_pv_q   <= r_dv_q;
            r_top2_q <= r_top1_q;
        end
    end

    // Stage S3: WS pass-down or OS accumulate/drain, plus sticky saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_q   <= '0;
            r_res_v_q <= 1'b0;
            r_acc_q   <= '0;
            r_sat_q   <= 1'b0;
        end else if (step_i) begin
            if (!mode_i) begin
                r_res_v_q <= r_pv_q;
                if (r_pv_q) begin
                    r_res_q <= w_ws_sat;
                    if (w_ws_clamp) begin
                        r_sat_q <= 1'b1;
                    end
                end
            end else if (clear_i) begin
                // Drain the old total; a product landing now seeds the next one.
                r_res_q   <= r_acc_q;
                r_res_v_q <= 1'b1;
                r_acc_q   <= r_pv_q ? w_prod_ext[ACC_W-1:0] : '0;
                r_sat_q   <= 1'b0;
            end else begin
                r_res_v_q <= 1'b0;
                if (r_pv_q) begin
                    r_acc_q <= w_os_sat;
                    if (w_os_clamp) begin
                        r_sat_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Debug read mux; narrow fields are sign-extended.
    always_comb begin
        dbg_data_o = '0;
        case (dbg_addr_i)
            3'd0:    dbg_data_o = ACC_W'(r_w_active);
            3'd1:    dbg_data_o = ACC_W'(r_w_shadow);
            3'd2:    dbg_data_o = ACC_W'(r_data_q);
            3'd3:    dbg_data_o = ACC_W'(r_prod_q);
            3'd4:    dbg_data_o = r_acc_q;
            3'd5:    dbg_data_o = r_res_q;
            3'd6:    dbg_data_o = {{(ACC_W-4){1'b0}}, r_sat_q, mode_i, r_pv_q, r_dv_q};
            default: dbg_data_o = '0;
        endcase
    end

    assign data_o   = r_data_q;
    assign data_v_o = r_dv_q;
    assign res_o    = r_res_q;
    assign res_v_o  = r_res_v_q;
    assign sat_o    = r_sat_q;

endmodule
